mips_muldiv_ctrl: RTL

MIPS_MULDIV_CTRL -- requirements
Module: mips_muldiv_ctrl

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/muldiv_step.sv | 35 +++
 rtl/mips_muldiv_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes (ALU and HI/LO group), mul/div FSM state type
// and an operand magnitude helper.
package mips_pkg;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   localparam int STEPS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Magnitude of a two's-complement value; -2**31 maps to 2**31 as unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the serial datapath: shift-add multiply (right shift of {hi,lo})
// or restoring shift-subtract divide (left shift, lo collects quotient bits).
module muldiv_step (
   input  logic        div_mode,
   input  logic [31:0] opnd,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [32:0] diff;

   // NOTE: every output gets a value on every path, so no latch is inferred.
   always_comb begin
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : 33'd0);
      shifted = {hi_in, lo_in[31]};
      diff    = shifted - {1'b0, opnd};
      hi_out  = sum[32:1];
      lo_out  = {sum[0], lo_in[31:1]};
      if (div_mode) begin
         // The partial remainder can exceed 32 bits before subtraction, so compare at 33.
         if (shifted >= {1'b0, opnd}) begin
            hi_out = diff[31:0];
            lo_out = {lo_in[30:0], 1'b1};
         end else begin
            hi_out = shifted[31:0];
            lo_out = {lo_in[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// MIPS HI/LO multiply/divide unit: 32-cycle serial mult/div, mthi/mtlo, mfhi/mflo.
// Divide support is built only when MIPS_MULDIV_DIV_EN is defined.
module mips_muldiv_ctrl
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  funct,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] result,
   output logic        div_by_zero
);

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] acc_hi, acc_lo, opnd;
   logic        is_div;
   logic        neg_q;
   logic [31:0] nxt_hi, nxt_lo;
   logic        step_div;
   logic [63:0] prod;
   logic        is_mult, is_divop, is_signed;
`ifdef MIPS_MULDIV_DIV_EN
   logic        neg_r;
   logic        dbz;
`endif

   assign is_mult   = (funct == F_MULT) || (funct == F_MULTU);
   assign is_divop  = (funct == F_DIV)  || (funct == F_DIVU);
   assign is_signed = (funct == F_MULT) || (funct == F_DIV);

`ifdef MIPS_MULDIV_DIV_EN
   assign step_div = is_div;
`else
   assign step_div = 1'b0;
`endif

   muldiv_step u_step (
      .div_mode (step_div),
      .opnd     (opnd),
      .hi_in    (acc_hi),
      .lo_in    (acc_lo),
      .hi_out   (nxt_hi),
      .lo_out   (nxt_lo)
   );

   assign prod   = neg_q ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
   assign busy   = (state != IDLE);
   assign result = (funct == F_MFHI) ? hi : (funct == F_MFLO) ? lo : 32'd0;

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 6'd0;
         hi          <= 32'd0;
         lo          <= 32'd0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         acc_hi      <= 32'd0;
         acc_lo      <= 32'd0;
         opnd        <= 32'd0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
         neg_r       <= 1'b0;
         dbz         <= 1'b0;
`endif
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (is_mult) begin
                  acc_hi <= 32'd0;
                  acc_lo <= abs32(B, is_signed);
                  opnd   <= abs32(A, is_signed);
                  neg_q  <= is_signed && (A[31] ^ B[31]);
                  is_div <= 1'b0;
                  cnt    <= 6'd0;
                  state  <= MUL;
               end else if (is_divop) begin
                  is_div <= 1'b1;
                  cnt    <= 6'd0;
`ifdef MIPS_MULDIV_DIV_EN
                  // On a zero divisor acc_hi carries A straight through to hi.
                  acc_hi <= (B == 32'd0) ? A : 32'd0;
                  acc_lo <= abs32(A, is_signed);
                  opnd   <= abs32(B, is_signed);
                  neg_q  <= is_signed && (A[31] ^ B[31]);
                  neg_r  <= is_signed && A[31];
                  dbz    <= (B == 32'd0);
                  state  <= (B == 32'd0) ? FIN : DIV;
`else
                  state  <= FIN;
`endif
               end else if (funct == F_MTHI) begin
                  hi   <= A;
                  done <= 1'b1;
               end else if (funct == F_MTLO) begin
                  lo   <= A;
                  done <= 1'b1;
               end
            end
            MUL, DIV: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               cnt    <= cnt + 6'd1;
               if (cnt == 6'(STEPS - 1))
                  state <= FIN;
            end
            FIN: begin
               done  <= 1'b1;
               state <= IDLE;
               if (!is_div) begin
                  {hi, lo} <= prod;
               end
`ifdef MIPS_MULDIV_DIV_EN
               else if (dbz) begin
                  hi          <= acc_hi;
                  lo          <= 32'hFFFF_FFFF;
                  div_by_zero <= 1'b1;
               end else begin
                  lo <= neg_q ? (32'd0 - acc_lo) : acc_lo;
                  hi <= neg_r ? (32'd0 - acc_hi) : acc_hi;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
